// File: rtl/key_event_decoder_pkg.sv
// Shared types and default timing for the key event decoder.
// - state_e: FSM state encoding (3 bits).
// - Def*: default timing constants for the 50 MHz board clock (1 ms tick).
package key_event_decoder_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StDown1 = 3'd1,
    StLong  = 3'd2,
    StWait2 = 3'd3,
    StDown2 = 3'd4
  } state_e;

  localparam int unsigned DefTickCyc  = 50000;
  localparam int unsigned DefLongTk   = 1000;
  localparam int unsigned DefRepeatTk = 200;
  localparam int unsigned DefDclickTk = 300;
  localparam int unsigned DefTkW      = 16;

endpackage

// File: rtl/key_event_decoder_tick_gen.sv
// Millisecond tick generator with a saturating tick counter.
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-high reset
//   clr    in   synchronous clear of prescaler and tick counter
//   tick   out  high for one cycle every TICK_CYC cycles after a clear
//   tk_cnt out  number of ticks since the last clear, saturating
module tick_gen #(
  parameter int unsigned TICK_CYC = 50000,
  parameter int unsigned TK_W     = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  output logic            tick,
  output logic [TK_W-1:0] tk_cnt
);

  localparam int unsigned PreW = $clog2(TICK_CYC);
  localparam logic [PreW-1:0] PreLast = PreW'(TICK_CYC - 1);

  logic [PreW-1:0] pre_q, pre_d;
  logic [TK_W-1:0] cnt_q, cnt_d;

  // Tick is decoded from the register so it lines up with the edge on which
  // the counter advances; the consumer can act on "counter reaches X" there.
  assign tick   = (pre_q == PreLast);
  assign tk_cnt = cnt_q;

  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (clr) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (tick) begin
      pre_d = '0;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/key_event_decoder.sv
// Turns a debounced active-low key level into one-cycle event pulses.
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   key_n        in   debounced key level, 0 = pressed
//   short_press  out  one-cycle pulse
//   double_press out  one-cycle pulse
//   long_press   out  one-cycle pulse
//   repeat_pulse out  one-cycle pulse while held past the long-press time
//   key_held     out  level, high in DOWN1, LONG or DOWN2
module key_event_decoder
  import key_event_decoder_pkg::*;
#(
  parameter int unsigned TICK_CYC  = DefTickCyc,
  parameter int unsigned LONG_TK   = DefLongTk,
  parameter int unsigned REPEAT_TK = DefRepeatTk,
  parameter int unsigned DCLICK_TK = DefDclickTk,
  parameter bit          DCLICK_EN = 1'b1,
  parameter int unsigned TK_W      = DefTkW
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic short_press,
  output logic double_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic key_held
);

  // A limit of L expires on the edge where the counter steps from L-1 to L.
  localparam logic [TK_W-1:0] LongLast   = TK_W'(LONG_TK - 1);
  localparam logic [TK_W-1:0] RepeatLast = TK_W'(REPEAT_TK - 1);
  localparam logic [TK_W-1:0] DclickLast = TK_W'(DCLICK_TK - 1);

  state_e state_q, state_d;
  logic   key_q;
  logic   press_edge, release_edge;
  logic   tick, timer_clr;
  logic [TK_W-1:0] tk_cnt;
  logic   long_to, repeat_to, dclick_to;
  logic   short_d, double_d, long_d, repeat_d;
  logic   short_q, double_q, long_q, repeat_q;

  // key_q resets to 0 so a key held through reset never looks like a new press.
  assign press_edge   = key_q & ~key_n;
  assign release_edge = ~key_q & key_n;

  assign long_to   = tick && (tk_cnt == LongLast);
  assign repeat_to = tick && (tk_cnt == RepeatLast);
  assign dclick_to = tick && (tk_cnt == DclickLast);

  tick_gen #(
    .TICK_CYC (TICK_CYC),
    .TK_W     (TK_W)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr),
    .tick   (tick),
    .tk_cnt (tk_cnt)
  );

  // Edge events are tested before timeouts so coincidences resolve to the
  // release (DOWN1, LONG) or to the press (WAIT2).
  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (press_edge) begin
          state_d = StDown1;
        end
      end
      StDown1: begin
        if (release_edge) begin
          if (DCLICK_EN) begin
            state_d = StWait2;
          end else begin
            state_d = StIdle;
            short_d = 1'b1;
          end
        end else if (long_to) begin
          state_d = StLong;
          long_d  = 1'b1;
        end
      end
      StLong: begin
        if (release_edge) begin
          state_d = StIdle;
        end else if (repeat_to) begin
          repeat_d = 1'b1;
        end
      end
      StWait2: begin
        if (press_edge) begin
          state_d  = StDown2;
          double_d = 1'b1;
        end else if (dclick_to) begin
          state_d = StIdle;
          short_d = 1'b1;
        end
      end
      StDown2: begin
        if (release_edge) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign timer_clr = (state_d != state_q) || repeat_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      key_q    <= 1'b0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_n;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
    end
  end

  assign short_press  = short_q;
  assign double_press = double_q;
  assign long_press   = long_q;
  assign repeat_pulse = repeat_q;
  assign key_held     = (state_q == StDown1) || (state_q == StLong) || (state_q == StDown2);

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench: stimulus pushes expected pulses (kind, cycle) into a
// per-DUT queue; a negedge monitor pops and compares whenever a pulse shows.
// u_dut0 has double-click detection on, u_dut1 has it off.
module tb_key_event_decoder;

  localparam int unsigned TC = 4;
  localparam int unsigned LT = 10;
  localparam int unsigned RT = 3;
  localparam int unsigned DT = 5;

  // Pulse vector order: {short, double, long, repeat}
  localparam logic [3:0] KShort  = 4'b1000;
  localparam logic [3:0] KDouble = 4'b0100;
  localparam logic [3:0] KLong   = 4'b0010;
  localparam logic [3:0] KRep    = 4'b0001;

  typedef struct {
    logic [3:0]  kind;
    int unsigned cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_n = 1'b1;
  logic key_n1 = 1'b1;
  logic s0, d0, l0, r0, h0;
  logic s1, d1, l1, r1, h1;

  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  exp_t qs[2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_event_decoder #(
    .TICK_CYC (TC), .LONG_TK (LT), .REPEAT_TK (RT), .DCLICK_TK (DT),
    .DCLICK_EN (1'b1), .TK_W (16)
  ) u_dut0 (
    .clk (clk), .rst (rst), .key_n (key_n),
    .short_press (s0), .double_press (d0), .long_press (l0),
    .repeat_pulse (r0), .key_held (h0)
  );

  key_event_decoder #(
    .TICK_CYC (TC), .LONG_TK (LT), .REPEAT_TK (RT), .DCLICK_TK (DT),
    .DCLICK_EN (1'b0), .TK_W (16)
  ) u_dut1 (
    .clk (clk), .rst (rst), .key_n (key_n1),
    .short_press (s1), .double_press (d1), .long_press (l1),
    .repeat_pulse (r1), .key_held (h1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int d, input logic [3:0] k, input int unsigned c);
    exp_t e;
    e.kind = k;
    e.cyc  = c;
    qs[d].push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor
  always @(negedge clk) begin
    logic [3:0] pv [2];
    exp_t e;
    pv[0] = {s0, d0, l0, r0};
    pv[1] = {s1, d1, l1, r1};
    for (int i = 0; i < 2; i++) begin
      if (pv[i] != 4'b0000) begin
        if (qs[i].size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected pulse dut%0d: got %b, want none (cycle %0d)", i, pv[i], cyc);
        end else begin
          e = qs[i].pop_front();
          check($sformatf("pulse kind dut%0d", i), {28'd0, pv[i]}, {28'd0, e.kind});
          check($sformatf("pulse cycle dut%0d", i), cyc, e.cyc);
        end
      end else if (qs[i].size() > 0 && qs[i][0].cyc <= cyc) begin
        e = qs[i].pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missed pulse dut%0d: got none, want %b at cycle %0d", i, e.kind, e.cyc);
      end
    end
  end

  initial begin
    int unsigned p;
    int unsigned r;

    // Reset state
    step(3);
    check("outputs in reset", {27'd0, s0, d0, l0, r0, h0}, 32'd0);
    rst = 1'b0;
    step(2);
    check("outputs after reset", {27'd0, s0, d0, l0, r0, h0}, 32'd0);

    // Short press: 12 cycles down, short_press 21 cycles after release
    key_n = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      check("key_held during short", {31'd0, h0}, 32'd1);
    end
    key_n = 1'b1;
    r = cyc;
    push(0, KShort, r + DT * TC + 1);
    step(1);
    check("key_held after release", {31'd0, h0}, 32'd0);
    step(35);

    // Double press: 12 down, 8 up, 30 down
    key_n = 1'b0;
    step(12);
    key_n = 1'b1;
    step(8);
    key_n = 1'b0;
    push(0, KDouble, cyc + 1);
    step(30);
    check("key_held in DOWN2", {31'd0, h0}, 32'd1);
    key_n = 1'b1;
    step(1);
    check("key_held after DOWN2", {31'd0, h0}, 32'd0);
    step(30);

    // Long press with one repeat, released at press+60
    p = cyc;
    key_n = 1'b0;
    push(0, KLong, p + LT * TC + 1);
    push(0, KRep, p + LT * TC + 1 + RT * TC);
    step(60);
    check("key_held in LONG", {31'd0, h0}, 32'd1);
    key_n = 1'b1;
    step(1);
    check("key_held after LONG", {31'd0, h0}, 32'd0);
    step(30);

    // Release exactly on the long timeout edge: still a short press
    key_n = 1'b0;
    step(LT * TC);
    key_n = 1'b1;
    push(0, KShort, cyc + DT * TC + 1);
    step(35);

    // Second press exactly on the WAIT2 timeout edge: double wins
    key_n = 1'b0;
    step(12);
    key_n = 1'b1;
    step(DT * TC);
    key_n = 1'b0;
    push(0, KDouble, cyc + 1);
    step(5);
    key_n = 1'b1;
    step(30);

    // Reset mid-LONG with key held, then key stays held across deassert
    key_n = 1'b0;
    push(0, KLong, cyc + LT * TC + 1);
    step(45);
    check("key_held before reset", {31'd0, h0}, 32'd1);
    rst = 1'b1;
    step(3);
    check("outputs during mid reset", {27'd0, s0, d0, l0, r0, h0}, 32'd0);
    rst = 1'b0;
    step(1);
    check("outputs after mid reset", {27'd0, s0, d0, l0, r0, h0}, 32'd0);
    step(50);
    check("held key ignored", {31'd0, h0}, 32'd0);
    key_n = 1'b1;
    step(30);
    check("release ignored", {31'd0, h0}, 32'd0);
    key_n = 1'b0;
    step(12);
    key_n = 1'b1;
    push(0, KShort, cyc + DT * TC + 1);
    step(35);

    // Double-click disabled: short_press one cycle after release
    key_n1 = 1'b0;
    step(12);
    check("dut1 key_held", {31'd0, h1}, 32'd1);
    key_n1 = 1'b1;
    push(1, KShort, cyc + 1);
    step(10);

    check("dut0 queue drained", qs[0].size(), 32'd0);
    check("dut1 queue drained", qs[1].size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
